adder_sched: RTL and testbench
==============================

Name: adder_sched

Overview:
- Shares one pipelined parallel-prefix adder (the stage chain built from gp_cell) between N_REQ requesters.
- Round-robin arbitration; at most one issue per cycle; each issue carries a tag.
- Tracks in-flight operations, routes each sum/carry back to its owner's result register, and holds it until the owner accepts it.
- Sits between the execution-unit clients and the shared adder datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- PIPE_LAT, 2, cycles from add_valid to add_sum valid at the adder output (>=1).
- TAG_W, 2, tag width = clog2(N_REQ), minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  request valid per requester.
- req_ready  out  N_REQ  request accepted (grant) this cycle.
- req_a  in  N_REQ*LEN_DATA  operand A, requester i at [i*LEN_DATA +: LEN_DATA].
- req_b  in  N_REQ*LEN_DATA  operand B, same packing.
- req_cin  in  N_REQ  carry-in per requester.
- add_valid  out  1  issue strobe to the adder.
- add_a  out  LEN_DATA  muxed operand A.
- add_b  out  LEN_DATA  muxed operand B.
- add_cin  out  1  muxed carry-in.
- add_sum  in  LEN_DATA  adder result, PIPE_LAT cycles after issue.
- add_cout  in  1  adder carry-out, aligned with add_sum.
- rsp_valid  out  N_REQ  result held for requester i.
- rsp_ready  in  N_REQ  requester i consumes its result.
- rsp_sum  out  N_REQ*LEN_DATA  per-requester result register.
- rsp_cout  out  N_REQ  per-requester carry-out.
- busy  out  N_REQ  requester i has an operation in flight or an unconsumed result.

Behaviour:
- Reset (rst_n=0, async): busy, rsp_valid, rsp_sum, rsp_cout, tag pipeline valids = 0; RR pointer = 0.
  - In-flight operations are discarded. Any add_sum arriving after reset release for a pre-reset issue is ignored, because its valid bit was cleared.
- Eligibility: elig[i] = req_valid[i] & ~busy[i], using registered busy. One outstanding operation per requester.
- Arbitration (combinational, one-hot):
  - Scan from RR pointer upward with wrap-around; the first eligible index wins.
  - req_ready = grant. add_valid = |grant.
  - add_a/add_b/add_cin = winner's operands; all zero when there is no grant.
- Pointer update: on grant of index g, pointer <= (g+1) mod N_REQ. It is unchanged when there is no grant.
- Issue: on grant g, busy[g] <= 1; tag pipeline stage 0 <= {valid=1, tag=g}.
- Tag pipeline: PIPE_LAT-deep shift register of {valid, tag}, advancing every cycle. No stall; the adder is fully pipelined.
- Retire: when the last stage is valid with tag t, rsp_sum[t] <= add_sum, rsp_cout[t] <= add_cout, rsp_valid[t] <= 1.
- Consume: rsp_valid[i] & rsp_ready[i] -> rsp_valid[i] <= 0, busy[i] <= 0 next cycle.
  - rsp_sum and rsp_cout keep their last value.
  - rsp_ready without rsp_valid has no effect.
- Simultaneous consume and new req_valid on the same i: no grant that cycle (busy still 1); eligible the next cycle. Minimum re-issue interval per requester = PIPE_LAT+2 cycles.
- A retire to t while rsp_valid[t]=1 cannot occur (one outstanding per requester). Assertion: flag it as an error in simulation.
- Requests are not required to stay stable across a wait, but requesters should hold req_valid until req_ready.
- Throughput: one issue per cycle across distinct requesters. A single requester can use at most 1/(PIPE_LAT+2) of issue slots.
- Latency: grant at cycle T -> rsp_valid high at T+PIPE_LAT+1.

Decomposition:
- LEN_DATA comes from define/main.def.v.
- Add the N_REQ default, the TAG_W derivation and the tag-pipe record width to that defines file as shared constants.
- Sub-module rr_arbiter (N parameter; inputs req, ptr; outputs one-hot grant and grant index). It is reused later for other shared units.
- Tag pipeline and result registers stay inline.

Test Plan (LEN_DATA=32, N_REQ=4, PIPE_LAT=2, stub adder = registered a+b+cin delayed 2):
- Single request: req 1 with a=0x0000_0005, b=0x0000_0003, cin=1 at T -> req_ready[1] at T; rsp_valid[1] at T+3 with sum=0x9, cout=0; busy[1] clears the cycle after rsp_ready.
- Carry-out: req 0 with a=0xFFFF_FFFF, b=0x1, cin=0 -> rsp_sum[0]=0x0, rsp_cout[0]=1.
- Round-robin: all 4 requesters valid continuously with rsp_ready=1 -> grant order 0,1,2,3 on consecutive cycles; then 0 again at the earliest cycle it is no longer busy. No requester is skipped.
- Backpressure: req 2 issues, rsp_ready[2]=0 for 10 cycles with req_valid[2] held -> no second grant to 2; rsp_sum[2] stable; grant to 2 one cycle after the consume.
- Pointer wrap: pointer=3, only req 0 and req 3 valid -> grant 3, then 0.
- Reset mid-operation: assert rst_n=0 one cycle after issuing req 1 -> all outputs 0 immediately; after release, no rsp_valid[1] appears even though the stub still emits a sum.

Source files
------------

// File: rtl/adder_sched_pkg.sv
// Shared constants and tag-pipe record for the shared adder scheduler.
// Also provides the tag-width helper used by the arbiter.
package adder_sched_pkg;

    localparam int LEN_DATA  = 32;
    localparam int N_REQ_DEF = 4;
    localparam int TAG_W_MAX = 3;

    function automatic int tag_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int TAG_W_DEF = tag_width(N_REQ_DEF);

    typedef struct packed {
        logic                 vld;
        logic [TAG_W_MAX-1:0] tag;
    } tag_rec_t;

    localparam int TAG_REC_W = $bits(tag_rec_t);

endpackage

// File: rtl/adder_sched_rr_arbiter.sv
// Round-robin arbiter: first request at or above ptr wins, with wrap.
// Produces a one-hot grant and the binary index of the winner.
module rr_arbiter
    import adder_sched_pkg::*;
#(
    parameter int N  = N_REQ_DEF,
    parameter int IW = tag_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/adder_sched.sv
// Shares one pipelined adder between N_REQ requesters, routing each
// tagged result back to its owner's held result register.
module adder_sched
    import adder_sched_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int PIPE_LAT = 2,
    parameter int TAG_W    = tag_width(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*LEN_DATA-1:0] req_a,
    input  logic [N_REQ*LEN_DATA-1:0] req_b,
    input  logic [N_REQ-1:0]          req_cin,
    output logic                      add_valid,
    output logic [LEN_DATA-1:0]       add_a,
    output logic [LEN_DATA-1:0]       add_b,
    output logic                      add_cin,
    input  logic [LEN_DATA-1:0]       add_sum,
    input  logic                      add_cout,
    output logic [N_REQ-1:0]          rsp_valid,
    input  logic [N_REQ-1:0]          rsp_ready,
    output logic [N_REQ*LEN_DATA-1:0] rsp_sum,
    output logic [N_REQ-1:0]          rsp_cout,
    output logic [N_REQ-1:0]          busy
);

    logic [N_REQ-1:0]     busy_q;
    logic [N_REQ-1:0]     rsp_valid_q;
    logic [N_REQ-1:0]     elig;
    logic [N_REQ-1:0]     grant;
    logic [N_REQ-1:0]     consume;
    logic [N_REQ-1:0]     hit;
    logic [TAG_W-1:0]     ptr_q;
    logic [TAG_W-1:0]     gidx;
    logic [TAG_W-1:0]     ptr_nxt;
    logic [TAG_REC_W-1:0] pipe_q [PIPE_LAT];
    tag_rec_t             last;

    assign elig = req_valid & ~busy_q;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (TAG_W)
    ) u_arb (
        .req   (elig),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (gidx)
    );

    assign req_ready = grant;
    assign add_valid = |grant;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign consume   = rsp_valid_q & rsp_ready;
    assign ptr_nxt   = (gidx == TAG_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            add_a   |= req_a[i*LEN_DATA +: LEN_DATA] & {LEN_DATA{grant[i]}};
            add_b   |= req_b[i*LEN_DATA +: LEN_DATA] & {LEN_DATA{grant[i]}};
            add_cin |= req_cin[i] & grant[i];
        end
    end

    // Tag pipe mirrors the adder latency so results find their owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < PIPE_LAT; p++) pipe_q[p] <= '0;
        end else begin
            pipe_q[0] <= {add_valid, TAG_W_MAX'(gidx)};
            for (int p = 1; p < PIPE_LAT; p++) pipe_q[p] <= pipe_q[p-1];
        end
    end

    always_comb begin
        last = tag_rec_t'(pipe_q[PIPE_LAT-1]);
        hit  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            hit[i] = last.vld && (last.tag == TAG_W_MAX'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            busy_q      <= '0;
            rsp_valid_q <= '0;
            rsp_sum     <= '0;
            rsp_cout    <= '0;
        end else begin
            if (add_valid) ptr_q <= ptr_nxt;
            for (int i = 0; i < N_REQ; i++) begin
                if (grant[i]) begin
                    busy_q[i] <= 1'b1;
                end else if (consume[i]) begin
                    busy_q[i] <= 1'b0;
                end
                if (hit[i]) begin
                    rsp_valid_q[i]                  <= 1'b1;
                    rsp_sum[i*LEN_DATA +: LEN_DATA] <= add_sum;
                    rsp_cout[i]                     <= add_cout;
                end else if (consume[i]) begin
                    rsp_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    a_no_overwrite: assert property (
        @(posedge clk) disable iff (!rst_n) (hit & rsp_valid_q) == '0
    );

endmodule

// File: tb/tb_adder_sched.sv
// Randomized scoreboard bench for adder_sched with a stub two-cycle adder.
// The reference model tracks arbitration and per-requester latency.
module tb_adder_sched;
    import adder_sched_pkg::*;

    localparam int N  = 4;
    localparam int PL = 2;
    localparam int W  = LEN_DATA;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_cin;
    logic             add_valid;
    logic [W-1:0]     add_a;
    logic [W-1:0]     add_b;
    logic             add_cin;
    logic [W-1:0]     add_sum;
    logic             add_cout;
    logic [N-1:0]     rsp_valid;
    logic [N-1:0]     rsp_ready;
    logic [N*W-1:0]   rsp_sum;
    logic [N-1:0]     rsp_cout;
    logic [N-1:0]     busy;

    adder_sched #(
        .N_REQ    (N),
        .PIPE_LAT (PL),
        .TAG_W    (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .add_valid (add_valid),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub adder: sum registered, then delayed once more; never reset.
    logic [W:0] s1, s2;
    always @(posedge clk) begin
        s1 <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
        s2 <= s1;
    end
    assign add_sum  = s2[W-1:0];
    assign add_cout = s2[W];

    int         n_vec = 0;
    int         n_err = 0;
    int         m_ptr = 0;
    bit [N-1:0] m_busy = '0;
    bit [N-1:0] m_rv = '0;
    int         m_cnt [N];
    logic [W:0] exp_q [N][$];

    initial for (int i = 0; i < N; i++) m_cnt[i] = 0;

    always @(negedge clk) begin
        int         g;
        int         j;
        logic [N-1:0] exp_g;
        logic [2*W+1:0] exp_iss;
        logic [W:0]  got;
        if (!rst_n) begin
            n_vec++;
            if (busy !== '0 || rsp_valid !== '0 || rsp_sum !== '0
                || rsp_cout !== '0) begin
                n_err++;
                $display("FAIL reset: busy=%b rsp_valid=%b cout=%b sum=%h want all 0",
                         busy, rsp_valid, rsp_cout, rsp_sum);
            end
            m_ptr  = 0;
            m_busy = '0;
            m_rv   = '0;
            for (int i = 0; i < N; i++) begin
                m_cnt[i] = 0;
                exp_q[i].delete();
            end
        end else begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (g < 0 && req_valid[j] && !m_busy[j]) g = j;
            end
            exp_g = '0;
            exp_iss = '0;
            if (g >= 0) begin
                exp_g[g] = 1'b1;
                exp_iss = {1'b1, req_cin[g], req_a[g*W +: W], req_b[g*W +: W]};
            end
            n_vec++;
            if (req_ready !== exp_g) begin
                n_err++;
                $display("FAIL grant: got %b want %b", req_ready, exp_g);
            end
            n_vec++;
            if ({add_valid, add_cin, add_a, add_b} !== exp_iss) begin
                n_err++;
                $display("FAIL issue: got %b %b %h %h want %h",
                         add_valid, add_cin, add_a, add_b, exp_iss);
            end
            n_vec++;
            if (busy !== m_busy) begin
                n_err++;
                $display("FAIL busy: got %b want %b", busy, m_busy);
            end
            n_vec++;
            if (rsp_valid !== m_rv) begin
                n_err++;
                $display("FAIL rsp_valid: got %b want %b", rsp_valid, m_rv);
            end
            // Monitor: every presented result must match its owner's queue head.
            for (int i = 0; i < N; i++) begin
                if (rsp_valid[i] === 1'b1) begin
                    got = {rsp_cout[i], rsp_sum[i*W +: W]};
                    n_vec++;
                    if (exp_q[i].size() == 0) begin
                        n_err++;
                        $display("FAIL rsp%0d: got %h want no response", i, got);
                    end else begin
                        if (got !== exp_q[i][0]) begin
                            n_err++;
                            $display("FAIL rsp%0d: got %h want %h", i, got, exp_q[i][0]);
                        end
                        if (rsp_ready[i]) void'(exp_q[i].pop_front());
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (m_rv[i] && rsp_ready[i]) begin
                    m_rv[i]   = 1'b0;
                    m_busy[i] = 1'b0;
                end
                if (m_cnt[i] > 0) begin
                    m_cnt[i]--;
                    if (m_cnt[i] == 0) m_rv[i] = 1'b1;
                end
            end
            if (g >= 0) begin
                m_busy[g] = 1'b1;
                m_cnt[g]  = PL;
                exp_q[g].push_back({1'b0, req_a[g*W +: W]}
                                   + {1'b0, req_b[g*W +: W]}
                                   + {{W{1'b0}}, req_cin[g]});
                m_ptr = (g + 1) % N;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic c);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = c;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            set_op(i, $urandom(), $urandom(), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        rsp_ready = '1;
        set_op(1, 32'h0000_0005, 32'h0000_0003, 1'b1);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        repeat (6) tick();

        set_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        repeat (6) tick();

        for (int c = 0; c < 16; c++) begin
            rand_ops();
            req_valid = '1;
            tick();
        end
        req_valid = '0;
        repeat (6) tick();

        rsp_ready[2] = 1'b0;
        set_op(2, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1);
        req_valid = 4'b0100;
        repeat (12) tick();
        rsp_ready[2] = 1'b1;
        repeat (3) tick();
        req_valid = '0;
        repeat (6) tick();

        req_valid = 4'b0100;
        tick();
        rand_ops();
        req_valid = 4'b1001;
        repeat (2) tick();
        req_valid = '0;
        repeat (6) tick();

        set_op(1, 32'hAAAA_0000, 32'h0000_5555, 1'b0);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (6) tick();

        for (int c = 0; c < 400; c++) begin
            rand_ops();
            req_valid = 4'($urandom());
            rsp_ready = 4'($urandom());
            tick();
        end
        req_valid = '0;
        rsp_ready = '1;
        repeat (8) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
